// File: rtl/text_buf_write_sched.sv
// text_buf_write_sched
//   Arbitrates the single write port of the 80x60 ASCII character buffer
//   that feeds the VGA text renderer. Two sources share the port:
//     - per-character writes from the terminal/cursor logic (valid/ready);
//     - an internal fill engine that clears the whole screen, or a single
//       text row, with FILL_CHAR.
//   The buffer sees at most one write per cycle, and no accepted write is lost.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready
//   are both high. req_ready depends only on the scheduler state and the two
//   clear pulses. It never depends on req_valid, so the requester may hold
//   req_valid high for as long as it likes while waiting.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   req_valid  character write request
//   req_ready  request is accepted on this edge if req_valid is also high
//   req_addr   linear address row*COLS+col
//   req_data   ASCII byte
//   clr_all    pulse: fill entire buffer with FILL_CHAR
//   clr_line   pulse: fill row clr_row with FILL_CHAR
//   clr_row    row to clear, sampled with clr_line
//   busy       a clear operation is writing this cycle
//   done       one-cycle pulse on the final write of a clear
//   err        one-cycle pulse: dropped out-of-range request or clr_row
//   buf_wr_en  buffer write enable (registered)
//   buf_addr   buffer write address (registered)
//   buf_data   buffer write data (registered)
module text_buf_write_sched #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 60,
  parameter int          ADDR_W    = 13,
  parameter int          ROW_W     = 6,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_data,
  input  logic              clr_all,
  input  logic              clr_line,
  input  logic [ROW_W-1:0]  clr_row,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data
);

  localparam int TOTAL = COLS * ROWS;

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] COLS_M1 = ADDR_W'(COLS - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLR_ALL  = 2'd1;
  localparam logic [1:0] ST_CLR_LINE = 2'd2;

  logic [1:0]        state;
  // Address of the final write of the clear that is running.
  logic [ADDR_W-1:0] clr_last;

  logic              row_ok;
  logic              addr_ok;
  logic              req_fire;
  logic              at_end;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] next_addr;

  // The range checks use one extra bit so that they stay correct even when
  // COLS*ROWS (or ROWS) is exactly a power of two.
  assign row_ok  = ({1'b0, clr_row}  < (ROW_W + 1)'(ROWS));
  assign addr_ok = ({1'b0, req_addr} < (ADDR_W + 1)'(TOTAL));

  // The row base is computed at full address width, so row*COLS cannot truncate.
  assign line_base = ADDR_W'(clr_row) * COLS_A;

  // While clearing, buf_addr holds the address being written in this cycle.
  // The fill engine therefore steps from it and needs no separate counter.
  assign next_addr = buf_addr + ADDR_W'(1);
  assign at_end    = (buf_addr == clr_last);

  // A clear pulse blocks the request on the same edge. The request then
  // stalls with its valid still high, so it is not lost.
  assign req_ready = (state == ST_IDLE) & ~clr_all & ~clr_line;
  assign req_fire  = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      clr_last  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      buf_wr_en <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (clr_all) begin
        // A full clear always wins. If a clear is already running, it is
        // restarted from address 0 and its done pulse is never issued.
        state     <= ST_CLR_ALL;
        clr_last  <= LAST_A;
        busy      <= 1'b1;
        buf_wr_en <= 1'b1;
        buf_addr  <= '0;
        buf_data  <= FILL_CHAR;
        done      <= (LAST_A == '0);
      end else begin
        case (state)
          ST_IDLE: begin
            if (clr_line) begin
              if (row_ok) begin
                state     <= ST_CLR_LINE;
                clr_last  <= line_base + COLS_M1;
                busy      <= 1'b1;
                buf_wr_en <= 1'b1;
                buf_addr  <= line_base;
                buf_data  <= FILL_CHAR;
                done      <= (COLS_M1 == '0);
              end else begin
                buf_wr_en <= 1'b0;
                err       <= 1'b1;
              end
            end else if (req_fire) begin
              if (addr_ok) begin
                buf_wr_en <= 1'b1;
                buf_addr  <= req_addr;
                buf_data  <= req_data;
              end else begin
                // The request is consumed but never written. Address and
                // data keep their previous values.
                buf_wr_en <= 1'b0;
                err       <= 1'b1;
              end
            end else begin
              buf_wr_en <= 1'b0;
            end
          end

          ST_CLR_ALL,
          ST_CLR_LINE: begin
            // clr_line is ignored here. The final write stays in a clear
            // state, so req_ready first rises in the cycle after done.
            if (at_end) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              buf_wr_en <= 1'b0;
            end else begin
              buf_wr_en <= 1'b1;
              buf_addr  <= next_addr;
              buf_data  <= FILL_CHAR;
              done      <= (next_addr == clr_last);
            end
          end

          default: begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            buf_wr_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_buf_write_sched.sv
// tb_text_buf_write_sched
//   Self-checking bench for text_buf_write_sched. A behavioural model keeps
//   the pending fill writes in a queue of addresses. Each cycle it pops one
//   write, or else serves a request, and the result is compared with the DUT
//   on every falling edge. Literal checks on directed scenarios pin the model.
module tb_text_buf_write_sched;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int TOTAL = COLS * ROWS;
  localparam int W     = 13;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_addr = '0;
  logic [7:0]   req_data = '0;
  logic         clr_all = 1'b0;
  logic         clr_line = 1'b0;
  logic [5:0]   clr_row = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic         buf_wr_en;
  logic [W-1:0] buf_addr;
  logic [7:0]   buf_data;

  text_buf_write_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .clr_all(clr_all), .clr_line(clr_line), .clr_row(clr_row),
    .busy(busy), .done(done), .err(err),
    .buf_wr_en(buf_wr_en), .buf_addr(buf_addr), .buf_data(buf_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];
  logic         m_live = 1'b0;
  logic         m_in_clear = 1'b0;
  logic         e_wr = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [W-1:0] e_addr = '0;
  logic [7:0]   e_data = '0;

  always @(posedge clk) begin : model
    logic rdy;
    if (rst) begin
      exp_q.delete();
      m_live = 1'b1; m_in_clear = 1'b0;
      e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_addr = '0; e_data = '0;
    end else if (m_live) begin
      rdy = !m_in_clear && !clr_all && !clr_line;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (clr_all) begin
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(W'(i));
      end else if (clr_line && !m_in_clear) begin
        if (clr_row < ROWS)
          for (int i = 0; i < COLS; i++) exp_q.push_back(W'(int'(clr_row) * COLS + i));
        else
          e_err = 1'b1;
      end
      if (exp_q.size() > 0) begin
        e_addr = exp_q.pop_front();
        e_wr = 1'b1; e_data = 8'h20; e_busy = 1'b1;
        e_done = (exp_q.size() == 0);
        m_in_clear = 1'b1;
      end else begin
        m_in_clear = 1'b0;
        e_busy = 1'b0;
        if (req_valid && rdy) begin
          if (req_addr < TOTAL) begin
            e_wr = 1'b1; e_addr = req_addr; e_data = req_data;
          end else begin
            e_wr = 1'b0; e_err = 1'b1;
          end
        end else begin
          e_wr = 1'b0;
        end
      end
    end
  end

  // ---------------- compare + monitor counters ----------------
  int cyc = 0;
  int wr_cnt = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0, w33_cnt = 0;
  int done_addr = -1, first_clr_addr = -1, done_cyc = -1, first_req_cyc = -1;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (m_live) begin
      chk("req_ready", 32'(req_ready), 32'(!m_in_clear && !clr_all && !clr_line));
      chk("wr_en", 32'(buf_wr_en), 32'(e_wr));
      chk("addr", 32'(buf_addr), 32'(e_addr));
      chk("data", 32'(buf_data), 32'(e_data));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
    end
    if (buf_wr_en) wr_cnt++;
    if (buf_wr_en && buf_data == 8'h33) w33_cnt++;
    if (buf_wr_en && !busy && first_req_cyc < 0) first_req_cyc = cyc;
    if (busy) busy_cnt++;
    if (busy && !prev_busy) first_clr_addr = int'(buf_addr);
    if (done) begin done_cnt++; done_addr = int'(buf_addr); done_cyc = cyc; end
    if (err) err_cnt++;
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0; w33_cnt = 0;
    done_addr = -1; first_clr_addr = -1; done_cyc = -1; first_req_cyc = -1;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin tick(); k++; end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
  endtask

  task automatic wait_writes(input int n, input int limit);
    int k = 0;
    while (wr_cnt < n && k < limit) begin tick(); k++; end
    chk("write_count_reached", 32'(wr_cnt >= n), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    chk("rst_wr_en", 32'(buf_wr_en), 0);
    chk("rst_addr", 32'(buf_addr), 0);
    chk("rst_data", 32'(buf_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    tick();

    // 1: single request, latency 1
    req_valid = 1'b1; req_addr = 13'd5; req_data = 8'h41;
    tick();
    req_valid = 1'b0;
    chk("t1_wr_en", 32'(buf_wr_en), 1);
    chk("t1_addr", 32'(buf_addr), 5);
    chk("t1_data", 32'(buf_data), 32'h41);
    tick();

    // 2: burst of four requests, one write per cycle
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = W'(i); req_data = 8'(8'h41 + i);
      tick();
      chk("t2_addr", 32'(buf_addr), 32'(i));
      chk("t2_data", 32'(buf_data), 32'(8'h41 + i));
    end
    req_valid = 1'b0;
    tick();
    chk("t2_writes", 32'(wr_cnt), 4);

    // 3: full clear with a request held valid throughout
    clear_counts();
    clr_all = 1'b1; req_valid = 1'b1; req_addr = 13'd100; req_data = 8'h5a;
    tick();
    clr_all = 1'b0;
    wait_done(TOTAL + 50);
    repeat (4) tick();
    req_valid = 1'b0;
    tick();
    chk("t3_done_cnt", 32'(done_cnt), 1);
    chk("t3_done_addr", 32'(done_addr), 4799);
    chk("t3_busy_cycles", 32'(busy_cnt), 4800);
    chk("t3_first_clr_addr", 32'(first_clr_addr), 0);
    chk("t3_req_after_done", 32'(first_req_cyc - done_cyc), 2);

    // 4: line clear of the last row, then an out-of-range row
    clear_counts();
    clr_line = 1'b1; clr_row = 6'd59;
    tick();
    clr_line = 1'b0;
    wait_done(200);
    repeat (2) tick();
    chk("t4_first_addr", 32'(first_clr_addr), 4720);
    chk("t4_done_addr", 32'(done_addr), 4799);
    chk("t4_busy_cycles", 32'(busy_cnt), 80);
    chk("t4_done_cnt", 32'(done_cnt), 1);
    clear_counts();
    clr_line = 1'b1; clr_row = 6'd60;
    tick();
    clr_line = 1'b0;
    repeat (2) tick();
    chk("t4_row60_err", 32'(err_cnt), 1);
    chk("t4_row60_writes", 32'(wr_cnt), 0);
    chk("t4_row60_busy", 32'(busy_cnt), 0);

    // 5: request loses to clr_all, then restart at write 100
    clear_counts();
    req_valid = 1'b1; req_addr = 13'd7; req_data = 8'h33; clr_all = 1'b1;
    tick();
    clr_all = 1'b0; req_valid = 1'b0;
    wait_writes(100, 300);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    wait_done(TOTAL + 50);
    repeat (2) tick();
    chk("t5_done_cnt", 32'(done_cnt), 1);
    chk("t5_done_addr", 32'(done_addr), 4799);
    chk("t5_restarted", 32'(busy_cnt > TOTAL), 1);
    chk("t5_req_dropped", 32'(w33_cnt), 0);

    // 6: reset in the middle of a clear, then an out-of-range request
    clear_counts();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    wait_writes(50, 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_wr_after_rst", 32'(buf_wr_en), 0);
    chk("t6_busy_after_rst", 32'(busy), 0);
    repeat (10) tick();
    chk("t6_no_done", 32'(done_cnt), 0);
    clear_counts();
    req_valid = 1'b1; req_addr = 13'd4800; req_data = 8'h11;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    chk("t6_oor_err", 32'(err_cnt), 1);
    chk("t6_oor_writes", 32'(wr_cnt), 0);

    // random traffic checked cycle by cycle against the model
    repeat (600) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = W'($urandom_range(0, 4900));
      req_data  = 8'($urandom_range(0, 255));
      clr_line  = ($urandom_range(0, 39) == 0);
      clr_row   = 6'($urandom_range(0, 63));
      clr_all   = ($urandom_range(0, 499) == 0);
      tick();
    end
    req_valid = 1'b0; clr_line = 1'b0; clr_all = 1'b0;
    begin
      int k = 0;
      while (busy && k < TOTAL + 50) begin tick(); k++; end
      chk("final_idle", 32'(busy), 0);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
